ddr_frame_reader: RTL and testbench

- Downstream consumer of the DDR frame buffers filled by the camera write adaptor.
- On a start handshake from the controller, reads one full frame from the selected ping-pong buffer over AXI4 read (16-beat x 32-bit bursts).
- Packs each burst into one 512-bit segment and emits Ethernet-style packets on the 520-bit packet bus. Each packet is one header segment followed by PAYLOAD_SEGS payload segments.
- Signals frame completion to the controller.

---
 rtl/camera_pkg.sv | 37 +++
 rtl/ddr_frame_reader_if.sv | 44 ++++
 rtl/ddr_frame_reader_beat_packer.sv | 54 +++++
 rtl/ddr_frame_reader.sv | 243 ++++++++++++++++++++++++
 tb/tb_ddr_frame_reader.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_pkg.sv
// Shared constants for the camera frame path: Ethernet header fields, DDR
// ping-pong buffer bases, segment geometry, packet-bus markers and the
// frame reader FSM states.
package camera_pkg;

    localparam logic [47:0] DST_MAC   = 48'hadad_adad_adad;
    localparam logic [47:0] SRC_MAC   = 48'hacac_acac_acac;
    localparam logic [15:0] DATA_TYPE = 16'h9000;

    localparam logic [31:0] BASE_ADDR0 = 32'h2BC0_0000;
    localparam logic [31:0] BASE_ADDR1 = 32'h2BE0_0000;

    // 614400 B frame split into 64-byte bursts
    localparam int unsigned FRAME_BURSTS    = 9600;
    localparam int unsigned SEG_BYTES       = 64;
    localparam int unsigned BEATS_PER_BURST = 16;

    // Packet-bus markers carried in pktout_data[519:518]
    localparam logic [1:0] MK_FIRST = 2'b10;
    localparam logic [1:0] MK_MID   = 2'b00;
    localparam logic [1:0] MK_LAST  = 2'b01;

    typedef enum logic [2:0] {
        StIdle,
        StAr,
        StRdata,
        StHdr,
        StSeg,
        StDone
    } rd_state_e;

    // Byte offset of a burst within a frame buffer
    function automatic logic [31:0] seg_offset(input logic [31:0] idx);
        return idx * SEG_BYTES;
    endfunction

endpackage

// File: rtl/ddr_frame_reader_if.sv
// AXI4 read-address and read-data channels used by the frame reader.
// master: the reader (drives AR*, RREADY); slave: the DDR interconnect.
interface ddr_frame_reader_if;

    logic        M_AXI_ARID;
    logic [31:0] M_AXI_ARADDR;
    logic [7:0]  M_AXI_ARLEN;
    logic [2:0]  M_AXI_ARSIZE;
    logic [1:0]  M_AXI_ARBURST;
    logic        M_AXI_ARLOCK;
    logic [3:0]  M_AXI_ARCACHE;
    logic [2:0]  M_AXI_ARPROT;
    logic [3:0]  M_AXI_ARQOS;
    logic        M_AXI_ARUSER;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;

    logic        M_AXI_RID;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RLAST;
    logic        M_AXI_RUSER;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
               M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
               M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER,
               M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID,
        input  M_AXI_RREADY
    );

endinterface

// File: rtl/ddr_frame_reader_beat_packer.sv
// beat_packer: assembles 16 x 32-bit AXI read beats into one 512-bit segment.
// Ports:
//   clk, areset          clock, async active-high reset
//   beat_valid_i/ready_i R channel handshake (ready is the reader's RREADY)
//   beat_data_i/resp_i/last_i  RDATA / RRESP / RLAST
//   asm_o                assembled segment, beat 0 in the LSBs
//   burst_done_o         16th beat accepted this cycle
//   beat_err_o           accepted beat had bad RRESP or misplaced/missing RLAST
module beat_packer (
    input  logic         clk,
    input  logic         areset,
    input  logic         beat_valid_i,
    input  logic         beat_ready_i,
    input  logic [31:0]  beat_data_i,
    input  logic [1:0]   beat_resp_i,
    input  logic         beat_last_i,
    output logic [511:0] asm_o,
    output logic         burst_done_o,
    output logic         beat_err_o
);

    logic [511:0] asm_q, asm_d;
    logic [3:0]   beat_cnt_q, beat_cnt_d;
    logic         fire;
    logic         last_beat;

    always_comb begin
        fire       = beat_valid_i & beat_ready_i;
        last_beat  = (beat_cnt_q == 4'd15);
        asm_d      = asm_q;
        beat_cnt_d = beat_cnt_q;
        if (fire) begin
            asm_d[{beat_cnt_q, 5'd0} +: 32] = beat_data_i;
            // Wraps to 0 after beat 15, ready for the next burst
            beat_cnt_d = beat_cnt_q + 4'd1;
        end
        burst_done_o = fire & last_beat;
        // Beat counting ignores RLAST; a mismatch is only flagged
        beat_err_o   = fire & ((beat_resp_i != 2'b00) | (beat_last_i != last_beat));
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            asm_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            asm_q      <= asm_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign asm_o = asm_q;

endmodule

// File: rtl/ddr_frame_reader.sv
// ddr_frame_reader: reads one frame from a DDR ping-pong buffer over AXI4
// (16-beat x 32-bit bursts, one outstanding) and emits it as packets on the
// 520-bit packet bus: a header segment then up to PAYLOAD_SEGS payload segments.
// Ports:
//   clk, areset                       clock, async active-high reset
//   ddr_read_start(_valid/_ready)     start handshake, ready only in idle
//   odd_even_flag                     buffer select sampled at start
//   ddr_read_finish(_valid/_ready)    frame done handshake
//   rd_err                            sticky AXI error, cleared on start
//   m_axi                             AXI4 read master
//   pktout_data/en, pktout_md/md_en   packet bus and header metadata
//   pkt_data_alf                      downstream almost-full
module ddr_frame_reader #(
    parameter int unsigned NUM_BURSTS   = camera_pkg::FRAME_BURSTS,
    parameter int unsigned PAYLOAD_SEGS = 8,
    parameter logic [31:0] BASE_ADDR0   = camera_pkg::BASE_ADDR0,
    parameter logic [31:0] BASE_ADDR1   = camera_pkg::BASE_ADDR1
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                ddr_read_start,
    input  logic                ddr_read_start_valid,
    output logic                ddr_read_start_ready,
    input  logic                odd_even_flag,
    output logic                ddr_read_finish,
    output logic                ddr_read_finish_valid,
    input  logic                ddr_read_finish_ready,
    output logic                rd_err,
    ddr_frame_reader_if.master  m_axi,
    output logic [519:0]        pktout_data,
    output logic                pktout_en,
    output logic [255:0]        pktout_md,
    output logic                pktout_md_en,
    input  logic                pkt_data_alf
);

    import camera_pkg::*;

    localparam int unsigned CntW = ($clog2(NUM_BURSTS + 1) > 14) ? $clog2(NUM_BURSTS + 1) : 14;
    localparam int unsigned SegW = ($clog2(PAYLOAD_SEGS + 1) > 1) ? $clog2(PAYLOAD_SEGS + 1) : 1;
    localparam logic [CntW-1:0] NumBurstsC   = CntW'(NUM_BURSTS);
    localparam logic [CntW-1:0] PayloadCntC  = CntW'(PAYLOAD_SEGS);
    localparam logic [SegW-1:0] PayloadSegsC = SegW'(PAYLOAD_SEGS);

    rd_state_e       state_q, state_d;
    logic            start_ready_q, start_ready_d;
    logic [31:0]     base_q, base_d;
    logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
    logic [15:0]     pkt_idx_q, pkt_idx_d;
    logic [SegW-1:0] seg_in_pkt_q, seg_in_pkt_d;
    logic            rd_err_q, rd_err_d;
    logic            arvalid_q, arvalid_d;
    logic [31:0]     araddr_q, araddr_d;
    logic            rready_q, rready_d;
    logic [519:0]    pkt_data_q, pkt_data_d;
    logic            pkt_en_q, pkt_en_d;
    logic [255:0]    md_q, md_d;
    logic            md_en_q, md_en_d;
    logic            finish_q, finish_d;

    logic [511:0]    asm;
    logic            burst_done;
    logic            beat_err;
    logic [CntW-1:0] remaining;
    logic [CntW-1:0] hdr_segs;
    logic [15:0]     hdr_len;
    logic [CntW-1:0] burst_next;
    logic [SegW-1:0] seg_next;
    logic            last_of_frame;
    logic            last_of_pkt;

    beat_packer u_beat_packer (
        .clk          (clk),
        .areset       (areset),
        .beat_valid_i (m_axi.M_AXI_RVALID),
        .beat_ready_i (rready_q),
        .beat_data_i  (m_axi.M_AXI_RDATA),
        .beat_resp_i  (m_axi.M_AXI_RRESP),
        .beat_last_i  (m_axi.M_AXI_RLAST),
        .asm_o        (asm),
        .burst_done_o (burst_done),
        .beat_err_o   (beat_err)
    );

    always_comb begin
        state_d       = state_q;
        start_ready_d = start_ready_q;
        base_d        = base_q;
        burst_cnt_d   = burst_cnt_q;
        pkt_idx_d     = pkt_idx_q;
        seg_in_pkt_d  = seg_in_pkt_q;
        rd_err_d      = rd_err_q;
        arvalid_d     = arvalid_q;
        araddr_d      = araddr_q;
        rready_d      = rready_q;
        pkt_data_d    = pkt_data_q;
        pkt_en_d      = 1'b0;
        md_d          = md_q;
        md_en_d       = 1'b0;
        finish_d      = finish_q;

        // Header length covers the segments this packet will actually carry
        remaining     = NumBurstsC - burst_cnt_q;
        hdr_segs      = (remaining > PayloadCntC) ? PayloadCntC : remaining;
        hdr_len       = 16'((32'(hdr_segs) + 32'd1) * SEG_BYTES);
        burst_next    = burst_cnt_q + 1'b1;
        seg_next      = seg_in_pkt_q + 1'b1;
        last_of_frame = (burst_next == NumBurstsC);
        last_of_pkt   = (seg_next == PayloadSegsC);

        unique case (state_q)
            StIdle: begin
                if (ddr_read_start && ddr_read_start_valid && start_ready_q) begin
                    base_d        = odd_even_flag ? BASE_ADDR1 : BASE_ADDR0;
                    burst_cnt_d   = '0;
                    pkt_idx_d     = '0;
                    seg_in_pkt_d  = '0;
                    rd_err_d      = 1'b0;
                    start_ready_d = 1'b0;
                    state_d       = StHdr;
                end
            end
            StHdr: begin
                if (!pkt_data_alf) begin
                    pkt_en_d   = 1'b1;
                    md_en_d    = 1'b1;
                    pkt_data_d = {MK_FIRST, 6'd0, DST_MAC, SRC_MAC, DATA_TYPE, pkt_idx_q, 384'd0};
                    md_d       = {224'd0, pkt_idx_q, hdr_len};
                    arvalid_d  = 1'b1;
                    araddr_d   = base_q + seg_offset(32'(burst_cnt_q));
                    state_d    = StAr;
                end
            end
            StAr: begin
                if (m_axi.M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StRdata;
                end
            end
            StRdata: begin
                if (beat_err) begin
                    rd_err_d = 1'b1;
                end
                if (burst_done) begin
                    rready_d = 1'b0;
                    state_d  = StSeg;
                end
            end
            StSeg: begin
                if (!pkt_data_alf) begin
                    pkt_en_d     = 1'b1;
                    pkt_data_d   = {(last_of_frame || last_of_pkt) ? MK_LAST : MK_MID, 6'd0, asm};
                    burst_cnt_d  = burst_next;
                    seg_in_pkt_d = seg_next;
                    if (last_of_frame) begin
                        finish_d = 1'b1;
                        state_d  = StDone;
                    end else if (last_of_pkt) begin
                        seg_in_pkt_d = '0;
                        pkt_idx_d    = pkt_idx_q + 16'd1;
                        state_d      = StHdr;
                    end else begin
                        arvalid_d = 1'b1;
                        araddr_d  = base_q + seg_offset(32'(burst_next));
                        state_d   = StAr;
                    end
                end
            end
            StDone: begin
                if (ddr_read_finish_ready) begin
                    finish_d      = 1'b0;
                    start_ready_d = 1'b1;
                    state_d       = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q       <= StIdle;
            start_ready_q <= 1'b1;
            base_q        <= '0;
            burst_cnt_q   <= '0;
            pkt_idx_q     <= '0;
            seg_in_pkt_q  <= '0;
            rd_err_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            araddr_q      <= '0;
            rready_q      <= 1'b0;
            pkt_data_q    <= '0;
            pkt_en_q      <= 1'b0;
            md_q          <= '0;
            md_en_q       <= 1'b0;
            finish_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            start_ready_q <= start_ready_d;
            base_q        <= base_d;
            burst_cnt_q   <= burst_cnt_d;
            pkt_idx_q     <= pkt_idx_d;
            seg_in_pkt_q  <= seg_in_pkt_d;
            rd_err_q      <= rd_err_d;
            arvalid_q     <= arvalid_d;
            araddr_q      <= araddr_d;
            rready_q      <= rready_d;
            pkt_data_q    <= pkt_data_d;
            pkt_en_q      <= pkt_en_d;
            md_q          <= md_d;
            md_en_q       <= md_en_d;
            finish_q      <= finish_d;
        end
    end

    assign ddr_read_start_ready  = start_ready_q;
    assign ddr_read_finish       = finish_q;
    assign ddr_read_finish_valid = finish_q;
    assign rd_err                = rd_err_q;
    assign pktout_data           = pkt_data_q;
    assign pktout_en             = pkt_en_q;
    assign pktout_md             = md_q;
    assign pktout_md_en          = md_en_q;

    // Fixed AR attributes: 16-beat INCR bursts of 4-byte beats
    assign m_axi.M_AXI_ARID    = 1'b0;
    assign m_axi.M_AXI_ARADDR  = araddr_q;
    assign m_axi.M_AXI_ARLEN   = 8'd15;
    assign m_axi.M_AXI_ARSIZE  = 3'b010;
    assign m_axi.M_AXI_ARBURST = 2'b01;
    assign m_axi.M_AXI_ARLOCK  = 1'b0;
    assign m_axi.M_AXI_ARCACHE = 4'b0011;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARQOS   = 4'b0000;
    assign m_axi.M_AXI_ARUSER  = 1'b0;
    assign m_axi.M_AXI_ARVALID = arvalid_q;
    assign m_axi.M_AXI_RREADY  = rready_q;

    logic unused_axi;
    assign unused_axi = ^{m_axi.M_AXI_RID, m_axi.M_AXI_RUSER};

endmodule

// File: tb/tb_ddr_frame_reader.sv
// Scoreboard bench for ddr_frame_reader with a 20-burst frame and 8-segment
// packets (3 packets of 8/8/4 payload segments).
module tb_ddr_frame_reader;

    localparam int unsigned NB = 20;
    localparam int unsigned PS = 8;

    typedef struct {
        logic [519:0] data;
        logic         md_en;
        logic [255:0] md;
    } seg_t;

    logic         clk = 1'b0;
    logic         areset;
    logic         ddr_read_start;
    logic         ddr_read_start_valid;
    logic         ddr_read_start_ready;
    logic         odd_even_flag;
    logic         ddr_read_finish;
    logic         ddr_read_finish_valid;
    logic         ddr_read_finish_ready;
    logic         rd_err;
    logic [519:0] pktout_data;
    logic         pktout_en;
    logic [255:0] pktout_md;
    logic         pktout_md_en;
    logic         pkt_data_alf;

    ddr_frame_reader_if axi_if ();

    ddr_frame_reader #(
        .NUM_BURSTS   (NB),
        .PAYLOAD_SEGS (PS)
    ) dut (
        .clk                   (clk),
        .areset                (areset),
        .ddr_read_start        (ddr_read_start),
        .ddr_read_start_valid  (ddr_read_start_valid),
        .ddr_read_start_ready  (ddr_read_start_ready),
        .odd_even_flag         (odd_even_flag),
        .ddr_read_finish       (ddr_read_finish),
        .ddr_read_finish_valid (ddr_read_finish_valid),
        .ddr_read_finish_ready (ddr_read_finish_ready),
        .rd_err                (rd_err),
        .m_axi                 (axi_if.master),
        .pktout_data           (pktout_data),
        .pktout_en             (pktout_en),
        .pktout_md             (pktout_md),
        .pktout_md_en          (pktout_md_en),
        .pkt_data_alf          (pkt_data_alf)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   seg_seen = 0;
    int   alf_viol = 0;
    bit   alf_window = 1'b0;
    bit   err_mode = 1'b0;
    seg_t exp_q[$];
    logic [31:0] addr_q[$];

    task automatic check(input string name, input logic [519:0] act, input logic [519:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Expected traffic for one frame: data beat k of burst b reads back as its address
    task automatic push_frame(input logic [31:0] base);
        int           nseg[3] = '{8, 8, 4};
        int           plen[3] = '{576, 576, 320};
        int           b = 0;
        seg_t         e;
        logic [511:0] asm;
        for (int p = 0; p < 3; p++) begin
            e.data  = {2'b10, 6'd0, 48'hadadadadadad, 48'hacacacacacac, 16'h9000, 16'(p), 384'd0};
            e.md_en = 1'b1;
            e.md    = {224'd0, 16'(p), 16'(plen[p])};
            exp_q.push_back(e);
            for (int s = 0; s < nseg[p]; s++) begin
                for (int k = 0; k < 16; k++) begin
                    asm[32*k +: 32] = base + 32'(64 * b) + 32'(4 * k);
                end
                e.data  = {(s == nseg[p] - 1) ? 2'b01 : 2'b00, 6'd0, asm};
                e.md_en = 1'b0;
                e.md    = '0;
                exp_q.push_back(e);
                addr_q.push_back(base + 32'(64 * b));
                b++;
            end
        end
    endtask

    task automatic start_frame(input logic flag, output bit ok);
        ok = 1'b0;
        @(posedge clk);
        #1;
        ddr_read_start       = 1'b1;
        ddr_read_start_valid = 1'b1;
        odd_even_flag        = flag;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ddr_read_start_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        ddr_read_start       = 1'b0;
        ddr_read_start_valid = 1'b0;
    endtask

    task automatic wait_finish(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (ddr_read_finish_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_segs(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (seg_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // AXI read slave: always ready for AR, returns address-valued beats
    initial begin : axi_slave
        logic        fire_ar;
        logic        fire_r;
        logic [31:0] ar_addr;
        logic [31:0] cur;
        logic        busy;
        int          beat;
        int          idx;
        busy = 1'b0;
        beat = 0;
        cur  = '0;
        axi_if.M_AXI_ARREADY = 1'b1;
        axi_if.M_AXI_RVALID  = 1'b0;
        axi_if.M_AXI_RDATA   = '0;
        axi_if.M_AXI_RRESP   = 2'b00;
        axi_if.M_AXI_RLAST   = 1'b0;
        axi_if.M_AXI_RID     = 1'b0;
        axi_if.M_AXI_RUSER   = 1'b0;
        forever begin
            @(negedge clk);
            fire_ar = axi_if.M_AXI_ARVALID && axi_if.M_AXI_ARREADY;
            fire_r  = axi_if.M_AXI_RVALID && axi_if.M_AXI_RREADY;
            ar_addr = axi_if.M_AXI_ARADDR;
            @(posedge clk);
            #1;
            if (areset) begin
                busy = 1'b0;
                beat = 0;
            end else begin
                if (fire_r) begin
                    beat++;
                    if (beat == 16) busy = 1'b0;
                end
                if (fire_ar) begin
                    busy = 1'b1;
                    beat = 0;
                    cur  = ar_addr;
                end
            end
            if (busy) begin
                idx = int'(cur[16:6]);
                axi_if.M_AXI_RVALID = 1'b1;
                axi_if.M_AXI_RDATA  = cur + 32'(4 * beat);
                axi_if.M_AXI_RRESP  = (err_mode && idx == 3 && beat == 5) ? 2'b10 : 2'b00;
                axi_if.M_AXI_RLAST  = (beat == 15) && !(err_mode && idx == 4);
            end else begin
                axi_if.M_AXI_RVALID = 1'b0;
                axi_if.M_AXI_RRESP  = 2'b00;
                axi_if.M_AXI_RLAST  = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every AR handshake and packet-bus strobe
    initial begin : monitor
        seg_t e;
        forever begin
            @(negedge clk);
            if (!areset) begin
                if (axi_if.M_AXI_ARVALID && axi_if.M_AXI_ARREADY) begin
                    if (addr_q.size() == 0) fail_now("araddr_unexpected");
                    else check("araddr", axi_if.M_AXI_ARADDR, addr_q.pop_front());
                end
                if (pktout_en) begin
                    seg_seen++;
                    if (alf_window) alf_viol++;
                    if (exp_q.size() == 0) begin
                        fail_now("segment_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        check("seg_data", pktout_data, e.data);
                        check("md_en", pktout_md_en, e.md_en);
                        if (e.md_en) check("md", pktout_md, e.md);
                    end
                end else if (pktout_md_en) begin
                    fail_now("md_en_without_segment");
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit ok;
        int s0;
        int v0;
        areset                = 1'b1;
        ddr_read_start        = 1'b0;
        ddr_read_start_valid  = 1'b0;
        odd_even_flag         = 1'b0;
        ddr_read_finish_ready = 1'b1;
        pkt_data_alf          = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", ddr_read_start_ready, 1'b1);
        check("rst_pktout_en", pktout_en, 1'b0);
        check("rst_md_en", pktout_md_en, 1'b0);
        check("rst_finish", {ddr_read_finish, ddr_read_finish_valid}, 2'b00);
        check("rst_rd_err", rd_err, 1'b0);
        check("rst_arvalid", axi_if.M_AXI_ARVALID, 1'b0);
        check("rst_rready", axi_if.M_AXI_RREADY, 1'b0);
        check("ar_fixed", {axi_if.M_AXI_ARLEN, axi_if.M_AXI_ARSIZE, axi_if.M_AXI_ARBURST,
                           axi_if.M_AXI_ARCACHE}, {8'd15, 3'b010, 2'b01, 4'b0011});
        areset = 1'b0;

        // Frame 1: buffer 1, almost-full stall mid-frame
        push_frame(32'h2BE0_0000);
        start_frame(1'b1, ok);
        check("start1_accepted", ok, 1'b1);
        s0 = seg_seen;
        wait_segs(s0 + 5, ok);
        check("frame1_progress", ok, 1'b1);
        @(posedge clk);
        #1;
        pkt_data_alf = 1'b1;
        @(posedge clk);
        #1;
        alf_window = 1'b1;
        v0 = alf_viol;
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("alf_rready_low", axi_if.M_AXI_RREADY, 1'b0);
        check("alf_no_issue", 32'(alf_viol), 32'(v0));
        alf_window = 1'b0;
        @(posedge clk);
        #1;
        pkt_data_alf = 1'b0;
        wait_finish(ok);
        check("finish1_seen", ok, 1'b1);
        check("finish1_flag", ddr_read_finish, 1'b1);
        @(negedge clk);
        check("finish1_pulse", ddr_read_finish_valid, 1'b0);
        check("idle1_start_ready", ddr_read_start_ready, 1'b1);
        check("frame1_all_issued", 32'(exp_q.size() + addr_q.size()), 32'd0);
        check("frame1_rd_err", rd_err, 1'b0);

        // Frame 2: buffer 0, RRESP error and missing RLAST, finish held off
        err_mode = 1'b1;
        ddr_read_finish_ready = 1'b0;
        push_frame(32'h2BC0_0000);
        start_frame(1'b0, ok);
        check("start2_accepted", ok, 1'b1);
        wait_finish(ok);
        err_mode = 1'b0;
        check("finish2_seen", ok, 1'b1);
        check("frame2_rd_err", rd_err, 1'b1);
        check("frame2_all_issued", 32'(exp_q.size() + addr_q.size()), 32'd0);

        // Start requested while finish is still pending must wait for idle
        push_frame(32'h2BC0_0000);
        @(posedge clk);
        #1;
        ddr_read_start       = 1'b1;
        ddr_read_start_valid = 1'b1;
        odd_even_flag        = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("finish_held", ddr_read_finish_valid, 1'b1);
            check("start_blocked", ddr_read_start_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        ddr_read_finish_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ddr_read_start_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_after_finish", ok, 1'b1);
        @(posedge clk);
        #1;
        ddr_read_start       = 1'b0;
        ddr_read_start_valid = 1'b0;
        @(negedge clk);
        check("start3_clears_rd_err", rd_err, 1'b0);
        check("start3_ready_drop", ddr_read_start_ready, 1'b0);

        // Frame 3: reset while a burst is being read
        s0 = seg_seen;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (seg_seen >= s0 + 3 && axi_if.M_AXI_RREADY) begin
                ok = 1'b1;
                break;
            end
        end
        check("frame3_in_rdata", ok, 1'b1);
        #2;
        areset = 1'b1;
        #1;
        check("arst_start_ready", ddr_read_start_ready, 1'b1);
        check("arst_axi", {axi_if.M_AXI_ARVALID, axi_if.M_AXI_RREADY, axi_if.M_AXI_ARADDR},
              34'd0);
        check("arst_pkt", {pktout_en, pktout_md_en, pktout_data}, 522'd0);
        check("arst_md", pktout_md, 256'd0);
        check("arst_finish_err", {ddr_read_finish_valid, ddr_read_finish, rd_err}, 3'b000);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        areset = 1'b0;

        // Frame 4: fresh frame from the start of buffer 0
        push_frame(32'h2BC0_0000);
        start_frame(1'b0, ok);
        check("start4_accepted", ok, 1'b1);
        wait_finish(ok);
        check("finish4_seen", ok, 1'b1);
        @(negedge clk);
        check("frame4_all_issued", 32'(exp_q.size() + addr_q.size()), 32'd0);
        check("frame4_rd_err", rd_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
